// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the 8-bit CPU fetch/decode path
package cpu_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } ps_state_t;

  localparam int PC_RESET   = 0;
  localparam int PAGE_W_DEF = 4;

  // Instruction fields: opcode in the high nibble, operand/jump target in the low nibble
  localparam int OPC_W      = 4;
  localparam int OPC_LSB    = 4;
  localparam int NIBBLE_LSB = 0;
  localparam logic [OPC_W-1:0] OP_JMP    = 4'hE;
  localparam logic [OPC_W-1:0] OP_JMP_NZ = 4'hF;

  function automatic logic jump_taken(input logic jmp, input logic jmp_nz, input logic z_flag);
    return jmp | (jmp_nz & ~z_flag);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with enable that sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - fetch address generation, stall, halt detect and retire count
module program_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int PAGE_W = PAGE_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jmp,
  input  logic              jmp_nz,
  input  logic [PAGE_W-1:0] ir_nibble,
  input  logic              z_flag,
  input  logic              hold,
  output logic [PC_W-1:0]   pm_addr,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count,
  output logic [7:0]        from_PS
);

  ps_state_t        state;
  logic [PC_W-1:0]  target;
  logic             taken;
  logic             advance;
  logic             self_halt;

  assign target    = {pc[PC_W-1:PAGE_W], ir_nibble};
  assign taken     = jump_taken(jmp, jmp_nz, z_flag);
  // Only an unconditional self-jump halts; jmp_nz loops are waits on the ALU
  assign self_halt = jmp && (target == pc);

  always_comb begin
    pm_addr = pc;
    advance = 1'b0;
    if (reset) begin
      pm_addr = PC_W'(PC_RESET);
    end else begin
      case (state)
        S_BOOT: pm_addr = PC_W'(PC_RESET);
        S_RUN, S_HOLD: begin
          if (!hold) begin
            advance = 1'b1;
            pm_addr = taken ? target : pc + PC_W'(1);
          end
        end
        default: pm_addr = pc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_BOOT;
      pc     <= PC_W'(PC_RESET);
      halted <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          pc    <= PC_W'(PC_RESET);
          state <= S_RUN;
        end
        S_RUN, S_HOLD: begin
          if (hold) begin
            state <= S_HOLD;
          end else begin
            pc <= pm_addr;
            if (self_halt) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        default: begin
          state  <= S_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_instr_count (
    .clk   (clk),
    .rst   (reset),
    .enable(advance),
    .count (instr_count)
  );

  generate
    if (PC_W >= 8) begin : g_tap_trunc
      assign from_PS = pc[7:0];
    end else begin : g_tap_ext
      assign from_PS = {{(8 - PC_W){1'b0}}, pc};
    end
  endgenerate

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - directed self-checking bench for program_sequencer
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        jmp;
  logic        jmp_nz;
  logic [3:0]  ir_nibble;
  logic        z_flag;
  logic        hold;
  logic [7:0]  pm_addr;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] instr_count;
  logic [7:0]  from_ps;

  logic        s_reset;
  logic [7:0]  s_pm_addr;
  logic [7:0]  s_pc;
  logic        s_halted;
  logic [3:0]  s_count;
  logic [7:0]  s_from_ps;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  program_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .ir_nibble  (ir_nibble),
    .z_flag     (z_flag),
    .hold       (hold),
    .pm_addr    (pm_addr),
    .pc         (pc),
    .halted     (halted),
    .instr_count(instr_count),
    .from_PS    (from_ps)
  );

  // Narrow counter so saturation is reachable in a few cycles
  program_sequencer #(
    .PC_W  (8),
    .PAGE_W(4),
    .CNT_W (4)
  ) dut_sat (
    .clk        (clk),
    .reset      (s_reset),
    .jmp        (1'b0),
    .jmp_nz     (1'b0),
    .ir_nibble  (4'h0),
    .z_flag     (1'b0),
    .hold       (1'b0),
    .pm_addr    (s_pm_addr),
    .pc         (s_pc),
    .halted     (s_halted),
    .instr_count(s_count),
    .from_PS    (s_from_ps)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_step();
    step();
    exp_cnt++;
  endtask

  task automatic adv_to(input logic [7:0] t);
    for (int i = 0; i < 300 && pc !== t; i++) run_step();
    chk("reach_pc", pc, t);
  endtask

  initial begin
    reset = 1'b1; s_reset = 1'b1;
    jmp = 1'b0; jmp_nz = 1'b0; ir_nibble = 4'h0; z_flag = 1'b0; hold = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_pm", pm_addr, 8'h00);
    chk("rst_halted", halted, 1'b0);
    chk("rst_cnt", instr_count, 16'h0000);

    #1 reset = 1'b0;
    #1;
    chk("boot_pm", pm_addr, 8'h00);
    step();
    chk("run0_pm", pm_addr, 8'h01);
    chk("run0_pc", pc, 8'h00);
    chk("run0_cnt", instr_count, 16'd0);
    run_step(); run_step(); run_step();
    chk("run3_pc", pc, 8'h03);
    chk("run3_pm", pm_addr, 8'h04);
    chk("run3_cnt", instr_count, 16'd3);

    // Stall on a pending jump at 0x10
    adv_to(8'h10);
    chk("pre_hold_cnt", instr_count, 16'd16);
    jmp = 1'b1; ir_nibble = 4'hC; hold = 1'b1;
    #1;
    chk("hold_pm0", pm_addr, 8'h10);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_pm", pm_addr, 8'h10);
      chk("hold_pc", pc, 8'h10);
      chk("hold_cnt", instr_count, 16'd16);
    end
    hold = 1'b0;
    #1;
    chk("unhold_pm", pm_addr, 8'h1C);
    run_step();
    chk("unhold_pc", pc, 8'h1C);
    chk("unhold_cnt", instr_count, 16'd17);
    jmp = 1'b0;

    // Conditional jump both ways
    adv_to(8'h20);
    jmp_nz = 1'b1; ir_nibble = 4'h8; z_flag = 1'b0;
    #1;
    chk("jnz_taken_pm", pm_addr, 8'h28);
    z_flag = 1'b1;
    #1;
    chk("jnz_not_pm", pm_addr, 8'h21);
    run_step();
    chk("jnz_not_pc", pc, 8'h21);
    jmp_nz = 1'b0; z_flag = 1'b0;

    adv_to(8'h3A);
    jmp = 1'b1; ir_nibble = 4'h5;
    #1;
    chk("jmp_pm", pm_addr, 8'h35);
    run_step();
    chk("jmp_pc", pc, 8'h35);
    jmp = 1'b0;

    // Both jump strobes high behaves as jmp
    jmp = 1'b1; jmp_nz = 1'b1; z_flag = 1'b1; ir_nibble = 4'hA;
    #1;
    chk("both_pm", pm_addr, 8'h3A);
    jmp = 1'b0; jmp_nz = 1'b0; z_flag = 1'b0;

    adv_to(8'hFF);
    #1;
    chk("wrap_pm", pm_addr, 8'h00);
    run_step();
    chk("wrap_pc", pc, 8'h00);
    chk("cnt_model", instr_count, 16'(exp_cnt));

    // Conditional self-jump does not halt, unconditional one does
    adv_to(8'h47);
    jmp_nz = 1'b1; ir_nibble = 4'h7; z_flag = 1'b0;
    #1;
    chk("jnz_self_pm", pm_addr, 8'h47);
    run_step();
    chk("jnz_self_halted", halted, 1'b0);
    chk("jnz_self_pc", pc, 8'h47);
    jmp_nz = 1'b0; jmp = 1'b1;
    #1;
    chk("self_pm", pm_addr, 8'h47);
    run_step();
    chk("halted", halted, 1'b1);
    for (int i = 0; i < 12; i++) begin
      hold = i[0];
      #1;
      chk("halt_pm", pm_addr, 8'h47);
      step();
    end
    hold = 1'b0;
    #1;
    chk("halt_pc", pc, 8'h47);
    chk("halt_from_ps", from_ps, 8'h47);
    chk("halt_still", halted, 1'b1);
    chk("halt_cnt", instr_count, 16'(exp_cnt));
    jmp = 1'b0;

    reset = 1'b1;
    #2;
    chk("unhalt_halted", halted, 1'b0);
    #1 reset = 1'b0;
    exp_cnt = 0;
    step();
    adv_to(8'h9C);

    // Asynchronous reset mid-cycle while a jump is presented
    jmp = 1'b1; ir_nibble = 4'h3;
    #1;
    chk("pre_arst_pm", pm_addr, 8'h93);
    reset = 1'b1;
    #1;
    chk("arst_pc", pc, 8'h00);
    chk("arst_pm", pm_addr, 8'h00);
    chk("arst_halted", halted, 1'b0);
    chk("arst_cnt", instr_count, 16'h0000);
    jmp = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("post_arst_boot_pm", pm_addr, 8'h00);
    step();
    chk("post_arst_pm", pm_addr, 8'h01);
    chk("post_arst_pc", pc, 8'h00);

    // Saturating retire counter
    #1 s_reset = 1'b0;
    step();
    repeat (14) step();
    chk("sat_e", s_count, 4'hE);
    step();
    chk("sat_f", s_count, 4'hF);
    repeat (5) step();
    chk("sat_hold", s_count, 4'hF);
    chk("sat_pc", s_pc, 8'h14);
    chk("sat_from_ps", s_from_ps, 8'h14);
    chk("sat_pm", s_pm_addr, 8'h15);
    chk("sat_halted", s_halted, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
